// File: rtl/mdu.sv
// Multiply/divide unit for the E stage; owns HI/LO.
// Fixed-latency mult/div with a Start/Busy stall handshake.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDOp,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] MDOut
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t      state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [31:0] hi, lo, hi_pend, lo_pend;
    logic [31:0] hi_n, lo_n, hi_pend_n, lo_pend_n;
    logic [31:0] res_hi, res_lo;
    logic signed [63:0] prod_s;
    logic [63:0] prod_u;
    logic        is_md, is_mult;

    assign is_md   = (MDOp >= 4'd1) && (MDOp <= 4'd4);
    assign is_mult = (MDOp == 4'd1) || (MDOp == 4'd2);
    assign Busy    = (state == RUN);
    assign Start   = is_md && !Busy;

    // Read port: HI for mfhi, LO for mflo, zero otherwise.
    always_comb begin
        MDOut = 32'd0;
        case (MDOp)
            4'd5:    MDOut = hi;
            4'd6:    MDOut = lo;
            default: MDOut = 32'd0;
        endcase
    end

    // Result of the operation on the E-stage operands; div by zero keeps HI/LO.
    always_comb begin
        res_hi = hi;
        res_lo = lo;
        prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u = {32'd0, A} * {32'd0, B};
        case (MDOp)
            4'd1: {res_hi, res_lo} = prod_s;
            4'd2: {res_hi, res_lo} = prod_u;
            4'd3: begin
                if (B != 32'd0) begin
                    if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
                        res_lo = 32'h8000_0000;
                        res_hi = 32'd0;
                    end else begin
                        res_lo = 32'($signed(A) / $signed(B));
                        res_hi = 32'($signed(A) % $signed(B));
                    end
                end
            end
            4'd4: begin
                if (B != 32'd0) begin
                    res_lo = A / B;
                    res_hi = A % B;
                end
            end
            default: ;
        endcase
    end

    // Next-state: issue, countdown and commit, and move-to writes when idle.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        hi_n      = hi;
        lo_n      = lo;
        hi_pend_n = hi_pend;
        lo_pend_n = lo_pend;
        case (state)
            IDLE: begin
                if (Start) begin
                    state_n   = RUN;
                    cnt_n     = is_mult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                    hi_pend_n = res_hi;
                    lo_pend_n = res_lo;
                end else if (MDOp == 4'd7) begin
                    hi_n = A;
                end else if (MDOp == 4'd8) begin
                    lo_n = A;
                end
            end
            RUN: begin
                cnt_n = cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    hi_n    = hi_pend;
                    lo_n    = lo_pend;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and register file update; reset discards any in-flight result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            hi_pend <= 32'd0;
            lo_pend <= 32'd0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            hi      <= hi_n;
            lo      <= lo_n;
            hi_pend <= hi_pend_n;
            lo_pend <= lo_pend_n;
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed table, corner sequences,
// and random ops against an arithmetic reference model.
module tb_mdu;

    logic        clk;
    logic        reset;
    logic [31:0] A, B;
    logic [3:0]  MDOp;
    logic        Start, Busy;
    logic [31:0] MDOut;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_hi, m_lo;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk),
        .reset(reset),
        .A(A),
        .B(B),
        .MDOp(MDOp),
        .Start(Start),
        .Busy(Busy),
        .MDOut(MDOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          cyc;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Read HI and LO through mfhi/mflo in the current cycle.
    task automatic read_hilo(input string name, input logic [31:0] eh, input logic [31:0] el);
        MDOp = 4'd5;
        #1 chk({name, " hi"}, MDOut, eh);
        MDOp = 4'd6;
        #1 chk({name, " lo"}, MDOut, el);
        MDOp = 4'd0;
    endtask

    // Count consecutive busy cycles, sampled at negedge, bounded.
    task automatic wait_busy(output int n);
        n = 0;
        while (Busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Issue a mult/div in the current cycle and check latency and result.
    task automatic issue(input string name, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input int cyc, input logic [31:0] eh, input logic [31:0] el);
        int n;
        MDOp = op;
        A = a;
        B = b;
        #1 chk({name, " start"}, 32'(Start), 32'd1);
        @(negedge clk);
        MDOp = 4'd0;
        wait_busy(n);
        chk({name, " busy cycles"}, n, cyc);
        read_hilo(name, eh, el);
    endtask

    // Move-to write in the current cycle, checked on the next cycle.
    task automatic move_to(input string name, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] eh, input logic [31:0] el);
        MDOp = op;
        A = a;
        #1 chk({name, " no start"}, 32'(Start), 32'd0);
        @(negedge clk);
        MDOp = 4'd0;
        read_hilo(name, eh, el);
    endtask

    // Reference model: plain 64-bit arithmetic on the operands.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint p, q, r;
        longint unsigned pu;
        case (op)
            4'd1: begin
                p = longint'($signed(a)) * longint'($signed(b));
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            4'd2: begin
                pu = longint'({32'd0, a}) * longint'({32'd0, b});
                m_hi = pu[63:32];
                m_lo = pu[31:0];
            end
            4'd3: if (b != 0) begin
                q = longint'($signed(a)) / longint'($signed(b));
                r = longint'($signed(a)) % longint'($signed(b));
                m_lo = q[31:0];
                m_hi = r[31:0];
            end
            4'd4: if (b != 0) begin
                m_lo = a / b;
                m_hi = a % b;
            end
            4'd7: m_hi = a;
            4'd8: m_lo = a;
            default: ;
        endcase
    endtask

    initial begin
        int n;
        logic [3:0] op;
        logic [31:0] ra, rb;
        logic [3:0] ops[6];

        vecs[0] = '{4'd1, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[1] = '{4'd2, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE};
        vecs[2] = '{4'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{4'd4, 32'd7, 32'd2, 10, 32'd1, 32'd3};
        vecs[4] = '{4'd7, 32'h1234, 32'd0, 0, 32'h1234, 32'd3};
        vecs[5] = '{4'd8, 32'h5678, 32'd0, 0, 32'h1234, 32'h5678};
        vecs[6] = '{4'd4, 32'd7, 32'd0, 10, 32'h1234, 32'h5678};
        vecs[7] = '{4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000};

        reset = 1'b1;
        A = 32'd0;
        B = 32'd0;
        MDOp = 4'd0;
        @(negedge clk);
        @(negedge clk);
        chk("reset busy", 32'(Busy), 32'd0);
        chk("reset mdout none", MDOut, 32'd0);
        MDOp = 4'd1;
        #1 chk("reset start follows op", 32'(Start), 32'd1);
        read_hilo("reset", 32'd0, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed table, issued back to back.
        foreach (vecs[i]) begin
            if (vecs[i].op == 4'd7 || vecs[i].op == 4'd8)
                move_to($sformatf("vec%0d", i), vecs[i].op, vecs[i].a,
                        vecs[i].hi, vecs[i].lo);
            else
                issue($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                      vecs[i].cyc, vecs[i].hi, vecs[i].lo);
        end

        // Busy behaviour: move-to and new issue ignored while running.
        @(negedge clk);
        move_to("pre mtlo", 4'd8, 32'h77, 32'd0, 32'h77);
        MDOp = 4'd1;
        A = 32'd3;
        B = 32'd4;
        @(negedge clk);
        MDOp = 4'd0;
        @(negedge clk);
        MDOp = 4'd7;
        A = 32'hDEAD;
        #1 chk("busy mthi start", 32'(Start), 32'd0);
        @(negedge clk);
        MDOp = 4'd6;
        #1 chk("busy mflo old", MDOut, 32'h77);
        MDOp = 4'd3;
        A = 32'd9;
        B = 32'd1;
        #1 chk("busy div start", 32'(Start), 32'd0);
        @(negedge clk);
        MDOp = 4'd0;
        wait_busy(n);
        chk("busy total cycles", n, 2);
        read_hilo("busy commit", 32'd0, 32'd12);

        // Reset in busy cycle 4 of a divide.
        @(negedge clk);
        MDOp = 4'd3;
        A = 32'd100;
        B = 32'd7;
        @(negedge clk);
        MDOp = 4'd0;
        repeat (3) @(negedge clk);
        chk("pre reset busy", 32'(Busy), 32'd1);
        reset = 1'b1;
        #1 chk("async reset busy", 32'(Busy), 32'd0);
        read_hilo("async reset", 32'd0, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue("post reset mult", 4'd1, 32'd2, 32'd3, 5, 32'd0, 32'd6);

        // Random ops against the reference model.
        ops = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8};
        m_hi = 32'd0;
        m_lo = 32'd6;
        for (int k = 0; k < 60; k++) begin
            op = ops[$urandom_range(0, 5)];
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = $urandom_range(1, 9);
                3: ra = 32'(-$signed(32'($urandom_range(0, 1000))));
                default: ;
            endcase
            model(op, ra, rb);
            if (op == 4'd7 || op == 4'd8)
                move_to($sformatf("rnd%0d", k), op, ra, m_hi, m_lo);
            else
                issue($sformatf("rnd%0d", k), op, ra, rb,
                      (op <= 4'd2) ? 5 : 10, m_hi, m_lo);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
